// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared types and constants for the memory dump reader
package mem_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/dump_fifo2.sv
// rtl/dump_fifo2.sv - two-entry {addr, data} FIFO with flush; head entry holds still under backpressure
module dump_fifo2
  import mem_dump_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic          empty_o,
  output logic [AW-1:0] out_addr_o,
  output logic [DW-1:0] out_data_o
);

  logic [AW-1:0] addr_q [FIFO_DEPTH];
  logic [DW-1:0] data_q [FIFO_DEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle push or pop; stale entries are simply abandoned.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign empty_o    = (count_q == 2'd0);
  assign out_addr_o = addr_q[rd_ptr_q];
  assign out_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - streams a range of RAM words with their addresses to a valid/ready sink
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic [1:0] fifo_count;
  logic       fifo_empty;
  logic       pop, abort_act, issue;
  logic [2:0] occupancy, limit;

  assign abort_act = abort && (state_q != ST_IDLE);
  assign pop       = !fifo_empty && out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q};
  assign limit     = 3'(FIFO_DEPTH) + {2'b0, pop};
  // Counting the same-cycle pop keeps one word per cycle flowing without ever overfilling.
  assign issue     = (state_q == ST_RUN) && (remaining_q != '0) && !abort_act && (occupancy < limit);

  dump_fifo2 #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (abort_act),
    .push_i     (inflight_q),
    .push_addr_i(inflight_addr_q),
    .push_data_i(mem_rdata),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .out_addr_o (out_addr),
    .out_data_o (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      remaining_q     <= '0;
      raddr_q         <= '0;
      inflight_addr_q <= '0;
      inflight_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      raddr_q         <= raddr_d;
      inflight_addr_q <= inflight_addr_d;
      inflight_q      <= inflight_d;
      done_q          <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (word_count != '0)) state_d = ST_RUN;
      ST_RUN:   if (issue && (remaining_q == (ADDR_WIDTH+1)'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (fifo_count == {1'b0, pop})) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  always_comb begin
    remaining_d     = remaining_q;
    raddr_d         = raddr_q;
    inflight_addr_d = inflight_addr_q;
    inflight_d      = issue;
    done_d          = 1'b0;
    if (state_q == ST_IDLE && start) begin
      raddr_d     = base_addr;
      remaining_d = word_count;
      done_d      = (word_count == '0);
    end
    if (issue) begin
      raddr_d         = raddr_q + ADDR_WIDTH'(1);
      remaining_d     = remaining_q - (ADDR_WIDTH+1)'(1);
      inflight_addr_d = raddr_q;
    end
    if (state_q == ST_DRAIN && state_d == ST_IDLE && !abort_act) begin
      done_d = 1'b1;
    end
    if (abort_act) begin
      remaining_d = '0;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    mem_re    = issue;
    mem_raddr = raddr_q;
    out_valid = !fifo_empty;
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - directed self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic        busy, done, mem_re, out_valid;
  logic [11:0] mem_raddr, out_addr;
  logic [31:0] mem_rdata, out_data;

  logic [31:0] ram [4096];

  int errors = 0;
  int checks = 0;

  logic [31:0] got_d [$];
  logic [11:0] got_a [$];
  bit          done_seen, ovf, unstable, done_bad;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  mem_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a dump and leaves time at cycle 1 (one cycle after start was sampled).
  task automatic kick(input logic [11:0] b, input logic [12:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_dump(input logic [11:0] b, input logic [12:0] n, input bit tog);
    int          issued = 0;
    int          acc = 0;
    bit          pst = 1'b0;
    logic [31:0] pd = '0;
    logic [11:0] pa = '0;
    got_d.delete();
    got_a.delete();
    done_seen = 1'b0;
    ovf       = 1'b0;
    unstable  = 1'b0;
    out_ready = 1'b1;
    kick(b, n);
    for (int c = 0; c < 80 && !done_seen; c++) begin
      out_ready = tog ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      if (done) done_seen = 1'b1;
      if (pst && (out_data !== pd || out_addr !== pa)) unstable = 1'b1;
      if (issued + int'(mem_re) - acc - int'(out_valid && out_ready) > 2) ovf = 1'b1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_a.push_back(out_addr);
        acc++;
      end
      if (mem_re) issued++;
      pst = out_valid && !out_ready;
      pd  = out_data;
      pa  = out_addr;
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic check_run(input string tag, input logic [11:0] b, input int n);
    logic [11:0] a;
    check({tag, "_count"}, got_d.size(), n);
    for (int k = 0; k < n; k++) begin
      a = b + 12'(k);
      check($sformatf("%s_addr%0d", tag, k), got_a[k], a);
      check($sformatf("%s_data%0d", tag, k), got_d[k], {20'hC0DE0, a});
    end
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_noovf"}, ovf, 0);
    check({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE0000 | i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; word_count = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_valid", out_valid, 0);
    check("rst_raddr", mem_raddr, 0);
    rst = 1'b0;
    tick();

    // Timing of a 4-word dump with the sink always ready.
    kick(12'h010, 13'd4);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_re", mem_re, 1);
    check("t1_c1_raddr", mem_raddr, 12'h010);
    tick();
    check("t1_c2_valid", out_valid, 0);
    tick();
    check("t1_c3_valid", out_valid, 1);
    check("t1_c3_data", out_data, 32'hC0DE0010);
    check("t1_c3_addr", out_addr, 12'h010);
    tick();
    check("t1_c4_data", out_data, 32'hC0DE0011);
    tick();
    check("t1_c5_data", out_data, 32'hC0DE0012);
    tick();
    check("t1_c6_data", out_data, 32'hC0DE0013);
    check("t1_c6_addr", out_addr, 12'h013);
    check("t1_c6_done", done, 0);
    tick();
    check("t1_c7_done", done, 1);
    check("t1_c7_busy", busy, 0);
    check("t1_c7_valid", out_valid, 0);
    tick();
    check("t1_c8_done", done, 0);

    run_dump(12'h010, 13'd4, 1'b1);
    check_run("t2_stall", 12'h010, 4);

    run_dump(12'hFFE, 13'd4, 1'b0);
    check_run("t3_wrap", 12'hFFE, 4);
    check("t3_a2", got_a[2], 12'h000);
    check("t3_d2", got_d[2], 32'hC0DE0000);
    check("t3_d1", got_d[1], 32'hC0DE0FFF);

    // Zero-length request.
    base_addr = 12'h020; word_count = 13'd0; start = 1'b1;
    #1;
    check("t4_c0_re", mem_re, 0);
    tick();
    start = 1'b0;
    check("t4_c1_done", done, 1);
    check("t4_c1_busy", busy, 0);
    check("t4_c1_re", mem_re, 0);
    tick();
    check("t4_c2_done", done, 0);
    check("t4_c2_re", mem_re, 0);

    // Abort after two handshakes of an 8-word dump.
    kick(12'h100, 13'd8);
    tick();
    tick();
    check("t5_c3_data", out_data, 32'hC0DE0100);
    tick();
    check("t5_c4_data", out_data, 32'hC0DE0101);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_re", mem_re, 0);
    done_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done || out_valid) done_bad = 1'b1;
      tick();
    end
    check("t5_quiet", done_bad, 0);
    run_dump(12'h200, 13'd2, 1'b0);
    check_run("t5_after", 12'h200, 2);

    // Reset in the middle of a dump.
    kick(12'h300, 13'd6);
    tick();
    tick();
    tick();
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_re", mem_re, 0);
    check("t6_raddr", mem_raddr, 0);
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_addr", out_addr, 0);
    rst = 1'b0;
    tick();
    run_dump(12'h400, 13'd3, 1'b1);
    check_run("t6_after", 12'h400, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
